vector_mac_accumulator: RTL and testbench



---
 rtl/dot_product_pkg.sv | 48 ++++
 rtl/lane_reduce.sv | 41 ++++
 rtl/vector_mac_accumulator.sv | 144 ++++++++++++++
 tb/tb_vector_mac_accumulator.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dot_product_pkg.sv
// Shared types and helpers for the dot-product datapath.
//   mode_e      : per-packet reduction mode (SUM of a, DOT of a*b)
//   acc_state_e : accumulator FSM states
//   sat_add     : signed add clamped to a w-bit two's-complement range
package dot_product_pkg;

  typedef enum logic {
    MODE_SUM = 1'b0,
    MODE_DOT = 1'b1
  } mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } acc_state_e;

  localparam int unsigned SAT_W = 64;

  typedef struct packed {
    logic             ovf;
    logic [SAT_W-1:0] sum;
  } sat_res_t;

  // Operands must already be sign-extended from w bits; one extra bit keeps the raw sum exact.
  function automatic sat_res_t sat_add(input logic signed [SAT_W-1:0] a,
                                       input logic signed [SAT_W-1:0] b,
                                       input int unsigned             w);
    logic signed [SAT_W:0] s;
    logic signed [SAT_W:0] hi;
    logic signed [SAT_W:0] lo;
    sat_res_t              r;
    s  = (SAT_W+1)'(a) + (SAT_W+1)'(b);
    hi = ((SAT_W+1)'(1) << (w - 1)) - (SAT_W+1)'(1);
    lo = -((SAT_W+1)'(1) << (w - 1));
    r.ovf = 1'b0;
    r.sum = s[SAT_W-1:0];
    if (s > hi) begin
      r.ovf = 1'b1;
      r.sum = hi[SAT_W-1:0];
    end else if (s < lo) begin
      r.ovf = 1'b1;
      r.sum = lo[SAT_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/lane_reduce.sv
// Combinational per-beat reduction: sum of a[i]*b[i] (dot=1) or sum of a[i] (dot=0),
// sign-extended to ACC_W.
//   dot      : select product (1) or pass-through of a (0)
//   a_data   : LANES signed IN_W elements, lane i at [i*IN_W +: IN_W]
//   b_data   : LANES signed IN_W elements, unused when dot=0
//   lane_sum : ACC_W-bit signed reduction of the beat
module lane_reduce #(
  parameter int unsigned LANES = 4,
  parameter int unsigned IN_W  = 8,
  parameter int unsigned ACC_W = 24
) (
  input  logic                  dot,
  input  logic [LANES*IN_W-1:0] a_data,
  input  logic [LANES*IN_W-1:0] b_data,
  output logic [ACC_W-1:0]      lane_sum
);

  localparam int unsigned PROD_W = 2 * IN_W;

  logic signed [IN_W-1:0]   a_el [LANES];
  logic signed [IN_W-1:0]   b_el [LANES];
  logic signed [PROD_W-1:0] prod [LANES];
  logic signed [ACC_W-1:0]  term [LANES];

  // Per-lane product or sign-extended element.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign a_el[i] = a_data[i*IN_W +: IN_W];
    assign b_el[i] = b_data[i*IN_W +: IN_W];
    assign prod[i] = PROD_W'(a_el[i]) * PROD_W'(b_el[i]);
    assign term[i] = dot ? ACC_W'(prod[i]) : ACC_W'(a_el[i]);
  end

  // Reduction across lanes; ACC_W is wide enough that this never overflows.
  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_sum = lane_sum + term[i];
    end
  end

endmodule

// File: rtl/vector_mac_accumulator.sv
// Streaming vector MAC: reduces each accepted beat to a lane sum and accumulates it over
// a packet delimited by in_last, then holds the result on a valid/ready output.
// Optional macro VECTOR_MAC_ACCUMULATOR_SATURATE_EN: clamp on overflow with a sticky
// per-packet out_ovf; otherwise wrap modulo 2^ACC_W and out_ovf stays 0.
//   clk, reset          : clock, synchronous active-high reset
//   mode                : 0 SUM, 1 DOT; taken from the first beat of a packet
//   in_valid/in_ready   : beat handshake; in_last marks the final beat
//   a_data, b_data      : LANES signed IN_W elements each
//   out_valid/out_ready : result handshake
//   out_data            : ACC_W signed result
//   out_count           : beats in packet, saturating
//   out_ovf             : clamp occurred in this packet
module vector_mac_accumulator
  import dot_product_pkg::*;
#(
  parameter int unsigned LANES = 4,
  parameter int unsigned IN_W  = 8,
  parameter int unsigned ACC_W = 24,
  parameter int unsigned CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mode,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_last,
  input  logic [LANES*IN_W-1:0] a_data,
  input  logic [LANES*IN_W-1:0] b_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_W-1:0]      out_data,
  output logic [CNT_W-1:0]      out_count,
  output logic                  out_ovf
);

  if (ACC_W < 2 * IN_W + $clog2(LANES) + 1) begin : g_acc_w_chk
    $error("vector_mac_accumulator: ACC_W too narrow for LANES/IN_W");
  end
`ifdef VECTOR_MAC_ACCUMULATOR_SATURATE_EN
  if (ACC_W >= SAT_W) begin : g_sat_w_chk
    $error("vector_mac_accumulator: ACC_W exceeds saturating adder width");
  end
`endif

  acc_state_e              state_q, state_d;
  mode_e                   mode_q, mode_d, mode_c;
  logic signed [ACC_W-1:0] acc_q, acc_d, lane_sum, add_val;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    ovf_q, ovf_d, add_ovf;
  logic                    accept_c;

  assign accept_c = in_valid && in_ready;

  // First beat uses the live mode pin; later beats use the latched packet mode.
  assign mode_c = (state_q == IDLE) ? mode_e'(mode) : mode_q;

  lane_reduce #(
    .LANES (LANES),
    .IN_W  (IN_W),
    .ACC_W (ACC_W)
  ) u_lane_reduce (
    .dot      (mode_c == MODE_DOT),
    .a_data   (a_data),
    .b_data   (b_data),
    .lane_sum (lane_sum)
  );

  // Accumulate step: clamped or wrapping.
`ifdef VECTOR_MAC_ACCUMULATOR_SATURATE_EN
  sat_res_t sat_r;
  always_comb begin
    sat_r   = sat_add(SAT_W'(acc_q), SAT_W'(lane_sum), ACC_W);
    add_val = ACC_W'(sat_r.sum);
    add_ovf = sat_r.ovf;
  end
`else
  always_comb begin
    add_val = acc_q + lane_sum;
    add_ovf = 1'b0;
  end
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state and datapath updates.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (accept_c) begin
          mode_d  = mode_c;
          acc_d   = lane_sum;
          cnt_d   = CNT_W'(1);
          ovf_d   = 1'b0;
          state_d = in_last ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (accept_c) begin
          acc_d = add_val;
          ovf_d = ovf_q | add_ovf;
          cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
          if (in_last) state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath and handshake registers; accumulator doubles as the held result.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q    <= MODE_SUM;
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      in_ready  <= (state_d != HOLD);
      out_valid <= (state_d == HOLD);
    end
  end

  assign out_data  = acc_q;
  assign out_count = cnt_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_vector_mac_accumulator.sv
// Self-checking bench for vector_mac_accumulator with a packet-level arithmetic model.
module tb_vector_mac_accumulator;

  localparam int unsigned LANES = 4;
  localparam int unsigned IN_W  = 8;
  localparam int unsigned ACC_W = 24;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned VW    = LANES * IN_W;

  logic             clk = 1'b0;
  logic             reset, mode, in_valid, in_ready, in_last;
  logic             out_valid, out_ready, out_ovf;
  logic [VW-1:0]    a_data, b_data;
  logic [ACC_W-1:0] out_data;
  logic [CNT_W-1:0] out_count;

  int n_pass = 0;
  int n_chk  = 0;

  logic [VW-1:0] pa[$];
  logic [VW-1:0] pb[$];
  longint        exp_data;
  bit            exp_ovf;
  int            exp_cnt;

  vector_mac_accumulator #(
    .LANES (LANES),
    .IN_W  (IN_W),
    .ACC_W (ACC_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_last   (in_last),
    .a_data    (a_data),
    .b_data    (b_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [63:0] accv(input longint v);
    return 64'(v & ((longint'(1) << ACC_W) - 1));
  endfunction

  // Beat value straight from the definition: sum of a*b or sum of a, as signed integers.
  function automatic longint beat_sum(input bit dot, input logic [VW-1:0] a, input logic [VW-1:0] b);
    longint s;
    int     x, y;
    s = 0;
    for (int i = 0; i < LANES; i++) begin
      x = int'($signed(a[i*IN_W +: IN_W]));
      y = int'($signed(b[i*IN_W +: IN_W]));
      s += dot ? longint'(x * y) : longint'(x);
    end
    return s;
  endfunction

  // Packet result over pa/pb with the configured overflow rule.
  task automatic model(input bit dot);
    longint hi, lo, t;
    hi = (longint'(1) << (ACC_W - 1)) - 1;
    lo = -(longint'(1) << (ACC_W - 1));
    exp_data = 0;
    exp_ovf  = 1'b0;
    exp_cnt  = pa.size();
    for (int k = 0; k < pa.size(); k++) begin
      t = exp_data + beat_sum(dot, pa[k], pb[k]);
`ifdef VECTOR_MAC_ACCUMULATOR_SATURATE_EN
      if (t > hi) begin t = hi; exp_ovf = 1'b1; end
      else if (t < lo) begin t = lo; exp_ovf = 1'b1; end
`else
      t = t & ((longint'(1) << ACC_W) - 1);
      if (t > hi) t = t - (longint'(1) << ACC_W);
`endif
      exp_data = t;
    end
  endtask

  task automatic send_wait(input string tag);
    int t;
    t = 0;
    while (!in_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready) check({tag, "_accept_timeout"}, 64'(in_ready), 64'd1);
    @(posedge clk); #1;
  endtask

  // Drive pa/pb as one packet, then check the result that must appear right after the last beat.
  task automatic send_packet(input string tag, input bit dot, input bit toggle, input int gap_pct);
    model(dot);
    for (int k = 0; k < pa.size(); k++) begin
      while (gap_pct != 0 && $urandom_range(99) < gap_pct) begin
        in_valid = 1'b0;
        mode     = ~dot;
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      a_data   = pa[k];
      b_data   = pb[k];
      in_last  = (k == pa.size() - 1);
      mode     = (toggle && k > 0) ? ~dot : dot;
      send_wait(tag);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_data"},  64'(out_data),  accv(exp_data));
    check({tag, "_count"}, 64'(out_count), 64'(exp_cnt));
    check({tag, "_ovf"},   64'(out_ovf),   64'(exp_ovf));
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_drained"}, 64'(out_valid), 64'd0);
    check({tag, "_ready"},   64'(in_ready),  64'd1);
  endtask

  task automatic fill_random(input int n);
    pa.delete();
    pb.delete();
    for (int k = 0; k < n; k++) begin
      pa.push_back($urandom());
      pb.push_back($urandom());
    end
  endtask

  task automatic fill_const(input int n, input logic [VW-1:0] a, input logic [VW-1:0] b);
    pa.delete();
    pb.delete();
    for (int k = 0; k < n; k++) begin
      pa.push_back(a);
      pb.push_back(b);
    end
  endtask

  initial begin
    reset = 1'b1; mode = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    out_ready = 1'b0; a_data = '0; b_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_data",  64'(out_data),  64'd0);
    check("rst_count", 64'(out_count), 64'd0);
    check("rst_ovf",   64'(out_ovf),   64'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("rst_ready", 64'(in_ready), 64'd1);

    // DOT, one beat {1,2,3,4}.{5,6,7,8}
    fill_const(1, 32'h04030201, 32'h08070605);
    send_packet("dot1", 1'b1, 1'b0, 0);
    consume("dot1");

    // Most-negative elements in SUM and DOT
    fill_const(2, 32'h80808080, 32'h0);
    send_packet("sum_neg", 1'b0, 1'b0, 0);
    consume("sum_neg");
    fill_const(1, 32'h80808080, 32'h80808080);
    send_packet("dot_neg", 1'b1, 1'b0, 0);
    consume("dot_neg");

    // Backpressure: next beat waits while result is held
    fill_random(3);
    send_packet("bp", 1'b1, 1'b0, 0);
    in_valid = 1'b1; in_last = 1'b1; mode = 1'b1;
    a_data = 32'h04030201; b_data = 32'h08070605;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("bp_ready",  64'(in_ready),  64'd0);
      check("bp_valid",  64'(out_valid), 64'd1);
      check("bp_stable", 64'(out_data),  accv(exp_data));
      check("bp_cnt",    64'(out_count), 64'd3);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_release_valid", 64'(out_valid), 64'd0);
    check("bp_release_ready", 64'(in_ready),  64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    fill_const(1, 32'h04030201, 32'h08070605);
    model(1'b1);
    check("bp_next_valid", 64'(out_valid), 64'd1);
    check("bp_next_data",  64'(out_data),  accv(exp_data));
    check("bp_next_count", 64'(out_count), 64'd1);
    consume("bp_next");

    // Reset mid-packet, then a clean packet
    fill_random(2);
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1; in_last = 1'b0; mode = 1'b1;
      a_data = pa[k]; b_data = pb[k];
      send_wait("abort");
    end
    in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_valid", 64'(out_valid), 64'd0);
    check("abort_data",  64'(out_data),  64'd0);
    check("abort_count", 64'(out_count), 64'd0);
    check("abort_ready", 64'(in_ready),  64'd1);
    fill_const(1, 32'h01010101, 32'h01010101);
    send_packet("post_abort", 1'b1, 1'b0, 0);
    consume("post_abort");

    // Long positive DOT packet: overflow boundary
    fill_const(131, 32'h7f7f7f7f, 32'h7f7f7f7f);
    send_packet("ovf", 1'b1, 1'b0, 0);
    consume("ovf");

    // Long negative SUM-of-products: negative boundary
    fill_const(131, 32'h7f7f7f7f, 32'h80808080);
    send_packet("ovf_neg", 1'b1, 1'b0, 0);
    consume("ovf_neg");

    // Mode toggled mid-packet, and the same packet with input gaps
    fill_random(6);
    send_packet("toggle_dot", 1'b1, 1'b1, 0);
    consume("toggle_dot");
    send_packet("gaps_dot", 1'b1, 1'b1, 40);
    consume("gaps_dot");
    send_packet("toggle_sum", 1'b0, 1'b1, 30);
    consume("toggle_sum");

    // Random packets
    for (int p = 0; p < 8; p++) begin
      fill_random(int'($urandom_range(8, 1)));
      send_packet("rand", 1'($urandom_range(1)), 1'($urandom_range(1)), int'($urandom_range(30)));
      consume("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
